// File: rtl/mc_phase_sequencer.sv
// Phase sequencer for the multi-cycle MIPS datapath: one-hot IF/ID/EX/MEM/WB phases with
// a per-opcode phase path chosen at decode, plus ALU function, retire count and halt.
module mc_phase_sequencer #(
    parameter int unsigned NPHASE = 5,
    parameter int unsigned CNTW   = 16
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [5:0]        Op,
    input  logic [5:0]        IRFunc,
    input  logic              stall,
    output logic [NPHASE-1:0] P,
    output logic [5:0]        Func,
    output logic              instr_done,
    output logic              illegal,
    output logic              halted,
    output logic [CNTW-1:0]   retired
);

    typedef enum logic [2:0] {
        StIf   = 3'd0,
        StId   = 3'd1,
        StEx   = 3'd2,
        StMem  = 3'd3,
        StWb   = 3'd4,
        StHalt = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic            has_mem_q, has_mem_d;
    logic            has_wb_q, has_wb_d;
    logic [5:0]      func_q, func_d;
    logic            illegal_q, illegal_d;
    logic [CNTW-1:0] retired_q, retired_d;

    logic       dec_mem, dec_wb, dec_halt, dec_ill;
    logic [5:0] dec_func;

    always_comb begin
        dec_mem  = 1'b0;
        dec_wb   = 1'b0;
        dec_halt = 1'b0;
        dec_ill  = 1'b0;
        dec_func = 6'h00;
        case (Op)
            6'h00: begin dec_wb = 1'b1; dec_func = IRFunc; end
            6'h23: begin dec_mem = 1'b1; dec_wb = 1'b1; dec_func = 6'h20; end
            6'h2B: begin dec_mem = 1'b1; dec_func = 6'h20; end
            6'h08: begin dec_wb = 1'b1; dec_func = 6'h20; end
            6'h04: dec_func = 6'h22;
            6'h02: dec_func = 6'h00;
            6'h3F: dec_halt = 1'b1;
            default: dec_ill = 1'b1;
        endcase
    end

    // Last phase of the latched path: EX if neither MEM nor WB, MEM if no WB, else WB.
    always_comb begin
        instr_done = 1'b0;
        case (state_q)
            StEx:    instr_done = !has_mem_q && !has_wb_q;
            StMem:   instr_done = !has_wb_q;
            StWb:    instr_done = 1'b1;
            default: instr_done = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        has_mem_d = has_mem_q;
        has_wb_d  = has_wb_q;
        func_d    = func_q;
        illegal_d = illegal_q;
        retired_d = retired_q;
        if (!stall) begin
            unique case (state_q)
                StIf: state_d = StId;
                StId: begin
                    state_d   = dec_halt ? StHalt : StEx;
                    has_mem_d = dec_mem;
                    has_wb_d  = dec_wb;
                    func_d    = dec_func;
                    illegal_d = dec_ill;
                end
                StEx:    state_d = has_mem_q ? StMem : (has_wb_q ? StWb : StIf);
                StMem:   state_d = has_wb_q ? StWb : StIf;
                StWb:    state_d = StIf;
                StHalt:  state_d = StHalt;
                default: state_d = StIf;
            endcase
            if (instr_done) begin
                retired_d = retired_q + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= StIf;
            has_mem_q <= 1'b0;
            has_wb_q  <= 1'b0;
            func_q    <= 6'h00;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            has_mem_q <= has_mem_d;
            has_wb_q  <= has_wb_d;
            func_q    <= func_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        P = '0;
        case (state_q)
            StIf:    P[0] = 1'b1;
            StId:    P[1] = 1'b1;
            StEx:    P[2] = 1'b1;
            StMem:   P[3] = 1'b1;
            StWb:    P[4] = 1'b1;
            default: P = '0;
        endcase
    end

    assign Func    = func_q;
    assign illegal = illegal_q;
    assign halted  = (state_q == StHalt);
    assign retired = retired_q;

endmodule

// File: tb/tb_mc_phase_sequencer.sv
// Directed bench for mc_phase_sequencer: expected per-cycle outputs are queued as stimulus is
// driven and popped against the DUT on the falling edge.
module tb_mc_phase_sequencer;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic [5:0] Op = 6'h00;
    logic [5:0] IRFunc = 6'h00;
    logic       stall = 1'b0;
    logic [4:0] P;
    logic [5:0] Func;
    logic       instr_done, illegal, halted;
    logic [3:0] retired;

    mc_phase_sequencer #(.NPHASE(5), .CNTW(4)) dut (
        .clk        (clk),
        .clr        (clr),
        .Op         (Op),
        .IRFunc     (IRFunc),
        .stall      (stall),
        .P          (P),
        .Func       (Func),
        .instr_done (instr_done),
        .illegal    (illegal),
        .halted     (halted),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] p;
        logic       done;
        logic [5:0] func;
        logic       ill;
        logic       halt;
        logic [3:0] ret;
    } exp_t;

    exp_t       sbq[$];
    int         n_assert = 0;
    int         n_fail = 0;
    logic [5:0] m_func = 6'h00;
    logic       m_ill = 1'b0;
    logic [3:0] m_ret = 4'd0;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [4:0] p, input logic done, input logic halt);
        exp_t e;
        e.p = p; e.done = done; e.func = m_func; e.ill = m_ill; e.halt = halt; e.ret = m_ret;
        sbq.push_back(e);
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            cmp({tag, " queue"}, 32'd0, 32'd1);
            return;
        end
        e = sbq.pop_front();
        cmp({tag, " P"}, 32'(P), 32'(e.p));
        cmp({tag, " done"}, 32'(instr_done), 32'(e.done));
        cmp({tag, " halted"}, 32'(halted), 32'(e.halt));
        cmp({tag, " retired"}, 32'(retired), 32'(e.ret));
        if (!e.halt) begin
            cmp({tag, " Func"}, 32'(Func), 32'(e.func));
            cmp({tag, " illegal"}, 32'(illegal), 32'(e.ill));
        end
    endtask

    // Called just after a rising edge; checks the current cycle on the falling edge.
    task automatic one_cycle(input logic st, input logic [4:0] p, input logic done,
                             input string tag);
        stall = st;
        push(p, done, 1'b0);
        @(negedge clk);
        pop_cmp(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut(input string tag);
        clr = 1'b0;
        #1;
        m_func = 6'h00; m_ill = 1'b0; m_ret = 4'd0;
        push(5'b00001, 1'b0, 1'b0);
        pop_cmp(tag);
        @(posedge clk);
        #1;
        clr = 1'b1;
        stall = 1'b0;
    endtask

    // Bench-side decode table: phase mask after ID, Func and illegal for an opcode.
    task automatic decode(input logic [5:0] op, input logic [5:0] fn, output logic [4:0] mask,
                          output logic [5:0] f, output logic ill);
        ill = 1'b0;
        case (op)
            6'h00: begin mask = 5'b10111; f = fn; end
            6'h23: begin mask = 5'b11111; f = 6'h20; end
            6'h2B: begin mask = 5'b01111; f = 6'h20; end
            6'h08: begin mask = 5'b10111; f = 6'h20; end
            6'h04: begin mask = 5'b00111; f = 6'h22; end
            6'h02: begin mask = 5'b00111; f = 6'h00; end
            default: begin mask = 5'b00111; f = 6'h00; ill = 1'b1; end
        endcase
    endtask

    task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input int sid,
                            input int slast, input string tag);
        logic [4:0] mask;
        logic [5:0] nf;
        logic       ni;
        int         last;
        int         reps;
        decode(op, fn, mask, nf, ni);
        last = mask[4] ? 4 : (mask[3] ? 3 : 2);
        Op = op;
        IRFunc = fn;
        for (int ph = 0; ph < 5; ph++) begin
            if (mask[ph]) begin
                reps = 1 + ((ph == 1) ? sid : 0) + ((ph == last) ? slast : 0);
                if (ph == 2) begin
                    m_func = nf;
                    m_ill = ni;
                    // A halt opcode after the decode edge must be ignored.
                    Op = 6'h3F;
                    IRFunc = 6'h3F;
                end
                for (int r = 0; r < reps; r++) begin
                    one_cycle(r != reps - 1, 5'(1 << ph), ph == last, tag);
                end
                if (ph == last) m_ret = m_ret + 4'd1;
            end
        end
        stall = 1'b0;
    endtask

    task automatic do_halt();
        Op = 6'h3F;
        one_cycle(1'b0, 5'b00001, 1'b0, "halt if");
        one_cycle(1'b0, 5'b00010, 1'b0, "halt id");
        for (int i = 0; i < 4; i++) begin
            stall = i[0];
            Op = 6'(i);
            push(5'b00000, 1'b0, 1'b1);
            @(negedge clk);
            pop_cmp("halted");
            @(posedge clk);
            #1;
        end
        stall = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        reset_dut("reset");
        do_instr(6'h00, 6'h20, 0, 0, "rtype add");
        do_instr(6'h00, 6'h2A, 0, 0, "rtype slt");
        do_instr(6'h23, 6'h00, 0, 0, "lw");
        do_instr(6'h04, 6'h00, 0, 0, "beq");
        do_instr(6'h2B, 6'h00, 3, 2, "sw stall");
        do_instr(6'h11, 6'h00, 0, 0, "illegal");
        do_instr(6'h08, 6'h00, 0, 0, "addi");
        do_halt();
        reset_dut("halt reset");
        for (int i = 0; i < 17; i++) do_instr(6'h02, 6'h00, 0, 0, "j wrap");
        cmp("wrap retired", 32'(retired), 32'd1);
        Op = 6'h23;
        one_cycle(1'b0, 5'b00001, 1'b0, "lw2 if");
        one_cycle(1'b0, 5'b00010, 1'b0, "lw2 id");
        m_func = 6'h20;
        one_cycle(1'b0, 5'b00100, 1'b0, "lw2 ex");
        cmp("lw2 mem P", 32'(P), 32'h8);
        reset_dut("mid reset");
        do_instr(6'h00, 6'h24, 0, 0, "after reset");
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_phase_sequencer.md
# mc_phase_sequencer

Parametrised phase generator for the multi-cycle MIPS datapath. It drives a one-hot phase vector (fetch, decode, execute, memory, write-back). The instruction length is chosen per opcode at decode time, so short instructions skip unused phases. It also supplies the ALU function code, retired-instruction count, stall hold, illegal-opcode flag and halt. It sits between the IR and the control-signal decode in the multi-cycle CPU top.

## Interface
Parameters:
- NPHASE, 5: width of the one-hot phase vector. Must be ≥5; bits above 4 are never asserted.
- CNTW, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- clr  in  1  reset, asynchronous, active-low.
- Op  in  6  opcode field of the IR; valid while P[1] is high.
- IRFunc  in  6  function field of the IR; valid while P[1] is high.
- stall  in  1  when high, all state holds for that cycle.
- P  out  NPHASE  one-hot phase: P[0] IF, P[1] ID, P[2] EX, P[3] MEM, P[4] WB.
- Func  out  6  ALU function code for the current instruction.
- instr_done  out  1  high during the final phase of an instruction.
- illegal  out  1  the current instruction's opcode is not in the decode table.
- halted  out  1  sequencer halted.
- retired  out  CNTW  count of completed instructions.

## Operation
- **Decode table**, sampled on the edge that ends P[1] (P[1]=1, stall=0). It latches the length L, the phase path and Func:
  - Op 6'h00 (R-type): L=4, path IF-ID-EX-WB, Func=IRFunc.
  - Op 6'h23 (lw): L=5, path IF-ID-EX-MEM-WB, Func=6'h20.
  - Op 6'h2B (sw): L=4, path IF-ID-EX-MEM, Func=6'h20.
  - Op 6'h08 (addi): L=4, path IF-ID-EX-WB, Func=6'h20.
  - Op 6'h04 (beq): L=3, path IF-ID-EX, Func=6'h22.
  - Op 6'h02 (j): L=3, path IF-ID-EX, Func=6'h00.
  - Op 6'h3F: halt. The next state is HALT.
  - Any other Op: L=3, path IF-ID-EX, Func=6'h00, illegal=1.
- **State machine:** IF → ID → (path per the table) → IF. The states are IF, ID, EX, MEM, WB and HALT.
  - EX goes to MEM (lw, sw), to WB (R-type, addi), or to IF (all others).
  - MEM goes to WB (lw) or to IF (sw).
  - WB always goes to IF.
- **HALT:** P is all zero and halted=1. Only clr leaves HALT; stall has no effect there.
- **Outputs while running:** exactly one bit of P is high in every non-HALT state. The P bit equals the state index.
- **instr_done** is combinational from the state: high in the last phase of the path (EX, MEM or WB as the table defines), low otherwise. It is never high in IF, ID or HALT.
- **retired** increments by 1 on each edge where instr_done=1 and stall=0. It wraps from 2^CNTW-1 to 0. A halt opcode does not count.
- **Func** and **illegal** hold their values from decode until the next decode edge. On that edge both are overwritten.
- **stall=1:** state, Func, illegal and retired all hold. stall is valid in any phase, including ID, where the decode is deferred until stall drops.

## Timing
- **Reset values (clr=0, asynchronous):** P=1 (IF), Func=0, instr_done=0, illegal=0, halted=0, retired=0.
- **Release:** the first edge after clr rises moves IF to ID.
- **Latency:** with stall held low, an instruction takes L cycles from its IF cycle to its last phase. The next IF follows immediately; there are no bubbles.
- **Decode timing:** Op and IRFunc are sampled only on the ID→next edge. Changes at any other time are ignored.
- **Reset mid-instruction:** asserting clr in any phase forces IF immediately. Counters and flags clear; a partially executed instruction is not counted.
- **Stall on the last phase:** stall=1 during the last phase holds the state and withholds the retired increment. instr_done stays high for every stalled cycle.

## Test plan
- **Reset, then R-type add:** Op=0, IRFunc=6'h20.
  - P sequence: 1, 2, 4, 16, 1.
  - Func=6'h20 from the EX cycle on; instr_done high only in the WB cycle; retired=1 after WB.
- **lw then beq back to back:**
  - P sequence: 1, 2, 4, 8, 16, 1, 2, 4, 1.
  - Func=6'h20, then 6'h22; retired=2 after 8 cycles.
- **Stall:** sw with stall=1 for 3 cycles in ID, then 2 cycles in MEM.
  - P holds 2 for 4 cycles and 8 for 3 cycles.
  - retired increments once, after the stall releases.
- **Illegal opcode:** Op=6'h11.
  - 3-phase path; illegal=1 from EX onward; Func=0.
  - A following addi clears illegal at its decode edge.
- **Halt:** Op=6'h3F.
  - After ID: P=0, halted=1, retired unchanged; stall toggling has no effect.
  - clr low: P=1, halted=0.
- **Wrap and mid-run reset:**
  - CNTW=4 with 17 j instructions: retired reads 0 then 1.
  - clr pulse during the MEM phase of a lw: P=1 and retired=0 asynchronously, before the next edge.
